// File: rtl/psram_burst_writer_if.sv
// psram_burst_writer_if: upstream write port plus PSRAM driver port; slave = writer side, master = upstream/driver side
interface psram_burst_writer_if;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_address;
   logic [7:0]  in_data;
   logic        flush;
   logic        psram_ready;
   logic        psram_enable;
   logic        psram_rw;
   logic        psram_set_address;
   logic [23:0] psram_address;
   logic        psram_next_byte_needed;
   logic        psram_write_data;
   logic [7:0]  psram_data;
   logic [15:0] bursts_issued;
   logic        overflow_flag;
   modport slave (
      input  in_valid, in_address, in_data, flush, psram_ready, psram_next_byte_needed,
      output in_ready, psram_enable, psram_rw, psram_set_address, psram_address,
             psram_write_data, psram_data, bursts_issued, overflow_flag
   );
   modport master (
      output in_valid, in_address, in_data, flush, psram_ready, psram_next_byte_needed,
      input  in_ready, psram_enable, psram_rw, psram_set_address, psram_address,
             psram_write_data, psram_data, bursts_issued, overflow_flag
   );
endinterface

// File: rtl/psram_burst_writer.sv
// psram_burst_writer: FIFO-buffers (address, byte) writes and streams contiguous runs as PSRAM write bursts; ports sysclk, reset, bus (psram_burst_writer_if.slave)
module psram_burst_writer #(
   parameter int FIFO_DEPTH  = 16,
   parameter int MAX_BURST   = 32,
   parameter int GAP_TIMEOUT = 8
) (
   input logic                 sysclk,
   input logic                 reset,
   psram_burst_writer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int GW = $clog2(GAP_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, SET_ADDR, WAIT_REQ, WAIT_GAP, CLOSE} state_t;
   state_t state, state_nxt;
   logic [23:0] fifo_addr [FIFO_DEPTH];
   logic [7:0]  fifo_data [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count, count_nxt;
   logic rdy, push, empty, start, flush_lat, flush_pend, contig, serve, page_end;
   logic [23:0] next_addr, head_addr, address;
   logic [7:0] head_data, data_r;
   logic [BW-1:0] burst_count;
   logic [GW-1:0] gap_count;
   logic [15:0] bursts;
   logic wd_r, ovf, enable, set_address;
   assign empty      = count == '0;
   assign push       = bus.in_valid && rdy;
   assign count_nxt  = count + (AW+1)'(push) - (AW+1)'(serve);
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];
   assign start      = state == IDLE && !empty && bus.psram_ready;
   assign flush_pend = flush_lat || bus.flush;
   assign contig     = !empty && head_addr == next_addr && burst_count < BW'(MAX_BURST) && !flush_pend;
   // WAIT_GAP already holds an accepted request, so it serves without a new pulse
   assign serve      = contig && ((state == WAIT_REQ && bus.psram_next_byte_needed) || state == WAIT_GAP);
   assign page_end   = next_addr[9:0] == 10'h3FF;
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = start ? SET_ADDR : IDLE;
         SET_ADDR: state_nxt = WAIT_REQ;
         WAIT_REQ: if (bus.psram_next_byte_needed)
                      state_nxt = serve ? (page_end ? CLOSE : WAIT_REQ) :
                                  (empty && !flush_pend && burst_count < BW'(MAX_BURST)) ? WAIT_GAP : CLOSE;
         WAIT_GAP: state_nxt = serve ? (page_end ? CLOSE : WAIT_REQ) :
                               (!empty || flush_pend || gap_count == GW'(GAP_TIMEOUT - 1)) ? CLOSE : WAIT_GAP;
         CLOSE:    state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end
   always_comb begin
      enable      = state == SET_ADDR || state == WAIT_REQ || state == WAIT_GAP;
      set_address = state == SET_ADDR;
      address     = set_address ? next_addr : '0;
   end
   always_ff @(posedge sysclk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.in_address;
         fifo_data[wr_ptr] <= bus.in_data;
      end
   end
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rdy         <= 1'b0;
         next_addr   <= '0;
         burst_count <= '0;
         gap_count   <= '0;
         flush_lat   <= 1'b0;
         data_r      <= '0;
         wd_r        <= 1'b0;
         bursts      <= '0;
         ovf         <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (serve) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         rdy   <= count_nxt != (AW+1)'(FIFO_DEPTH);
         if (start) next_addr <= head_addr;
         else if (serve) next_addr <= next_addr + 24'd1;
         if (set_address) begin
            burst_count <= '0;
            bursts      <= bursts + 16'd1;
         end else if (serve) burst_count <= burst_count + BW'(1);
         gap_count <= state == WAIT_GAP ? gap_count + GW'(1) : '0;
         // a flush seen while idle or just before returning to idle belongs to no burst
         flush_lat <= state != IDLE && state_nxt != CLOSE && flush_pend;
         if (serve) data_r <= head_data;
         wd_r <= serve;
         ovf  <= ovf || (bus.in_valid && !rdy);
      end
   end
   assign bus.in_ready          = rdy;
   assign bus.psram_enable      = enable;
   assign bus.psram_rw          = enable;
   assign bus.psram_set_address = set_address;
   assign bus.psram_address     = address;
   assign bus.psram_write_data  = wd_r;
   assign bus.psram_data        = data_r;
   assign bus.bursts_issued     = bursts;
   assign bus.overflow_flag     = ovf;
endmodule

// File: tb/tb_psram_burst_writer.sv
// tb_psram_burst_writer: scoreboard bench driving directed write streams into psram_burst_writer
module tb_psram_burst_writer;
   localparam logic [1:0] K_SET = 2'd0, K_DATA = 2'd1, K_CLOSE = 2'd2;
   typedef struct packed {logic [1:0] kind; logic [23:0] val;} ev_t;
   logic sysclk = 1'b0;
   logic reset = 1'b1;
   logic prev_en = 1'b0;
   int checks = 0;
   int errors = 0;
   ev_t sb[$];
   psram_burst_writer_if bus();
   psram_burst_writer dut (.sysclk(sysclk), .reset(reset), .bus(bus));
   always #5 sysclk = ~sysclk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask
   task automatic ev(input logic [1:0] k, input logic [23:0] v);
      sb.push_back({k, v});
   endtask
   task automatic take(input logic [1:0] k, input logic [23:0] v);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d val %h, required no event", k, v);
      end else begin
         e = sb.pop_front();
         if (e.kind !== k || e.val !== v) begin
            errors++;
            $display("FAIL event_order: got kind %0d val %h, required kind %0d val %h", k, v, e.kind, e.val);
         end
      end
   endtask
   always @(negedge sysclk) begin
      if (reset) prev_en = 1'b0;
      else begin
         if (bus.psram_set_address && bus.psram_write_data) begin
            checks++;
            errors++;
            $display("FAIL pulse_overlap: got set_address=1 write_data=1, required not both");
         end
         if (bus.psram_enable) chk("psram_rw", {31'd0, bus.psram_rw}, 32'd1);
         if (bus.psram_set_address) take(K_SET, bus.psram_address);
         if (bus.psram_write_data) take(K_DATA, {16'h0, bus.psram_data});
         if (prev_en && !bus.psram_enable) take(K_CLOSE, 24'h0);
         prev_en = bus.psram_enable;
      end
   end
   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask
   task automatic push(input logic [23:0] a, input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_address = a;
      bus.in_data = d;
      tick();
      bus.in_valid = 1'b0;
   endtask
   task automatic req();
      bus.psram_next_byte_needed = 1'b1;
      tick();
      bus.psram_next_byte_needed = 1'b0;
   endtask
   task automatic pulse_flush();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
   endtask
   task automatic do_reset();
      bus.psram_ready = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask
   initial begin
      int pushed;
      bus.in_valid = 1'b0;
      bus.in_address = '0;
      bus.in_data = '0;
      bus.flush = 1'b0;
      bus.psram_ready = 1'b0;
      bus.psram_next_byte_needed = 1'b0;
      #2;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_enable", {31'd0, bus.psram_enable}, 32'd0);
      chk("rst_bursts", {16'd0, bus.bursts_issued}, 32'd0);
      chk("rst_overflow", {31'd0, bus.overflow_flag}, 32'd0);
      chk("rst_write_data", {31'd0, bus.psram_write_data}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
      // four contiguous bytes in one burst, closed by gap timeout
      ev(K_SET, 24'h000100);
      for (int i = 0; i < 4; i++) begin
         push(24'h000100 + 24'(i), 8'hA0 + 8'(i));
         ev(K_DATA, {16'h0, 8'hA0 + 8'(i)});
      end
      ev(K_CLOSE, 0);
      bus.psram_ready = 1'b1;
      repeat (3) tick();
      repeat (4) begin req(); tick(); end
      req();
      repeat (12) tick();
      chk("bursts_contig", {16'd0, bus.bursts_issued}, 32'd1);
      do_reset();
      // non-contiguous head closes and reopens
      push(24'h000010, 8'hB0);
      push(24'h000020, 8'hB1);
      ev(K_SET, 24'h000010); ev(K_DATA, 24'hB0); ev(K_CLOSE, 0);
      ev(K_SET, 24'h000020); ev(K_DATA, 24'hB1); ev(K_CLOSE, 0);
      bus.psram_ready = 1'b1;
      repeat (3) tick();
      req(); tick();
      req();
      repeat (4) tick();
      req(); tick();
      req();
      repeat (12) tick();
      chk("bursts_noncontig", {16'd0, bus.bursts_issued}, 32'd2);
      do_reset();
      // 40 bytes split by the 32-byte burst limit
      ev(K_SET, 24'h000000);
      for (int i = 0; i < 32; i++) ev(K_DATA, {16'h0, 8'(i) ^ 8'h5A});
      ev(K_CLOSE, 0);
      ev(K_SET, 24'h000020);
      for (int i = 32; i < 40; i++) ev(K_DATA, {16'h0, 8'(i) ^ 8'h5A});
      ev(K_CLOSE, 0);
      for (int i = 0; i < 8; i++) push(24'(i), 8'(i) ^ 8'h5A);
      pushed = 8;
      bus.psram_ready = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 32; k++) begin
         req();
         if (pushed < 40) begin
            push(24'(pushed), 8'(pushed) ^ 8'h5A);
            pushed++;
         end
      end
      chk("fifo_not_full_midway", {31'd0, bus.in_ready}, 32'd1);
      req();
      repeat (4) tick();
      repeat (8) begin req(); tick(); end
      req();
      repeat (12) tick();
      chk("bursts_max", {16'd0, bus.bursts_issued}, 32'd2);
      do_reset();
      // 1 KiB page boundary and 24-bit address wrap
      push(24'h0003FE, 8'hC0);
      push(24'h0003FF, 8'hC1);
      push(24'h000400, 8'hC2);
      ev(K_SET, 24'h0003FE); ev(K_DATA, 24'hC0); ev(K_DATA, 24'hC1); ev(K_CLOSE, 0);
      ev(K_SET, 24'h000400); ev(K_DATA, 24'hC2); ev(K_CLOSE, 0);
      bus.psram_ready = 1'b1;
      repeat (3) tick();
      req(); tick();
      req();
      repeat (4) tick();
      req(); tick();
      req();
      repeat (12) tick();
      bus.psram_ready = 1'b0;
      push(24'hFFFFFF, 8'hE0);
      ev(K_SET, 24'hFFFFFF); ev(K_DATA, 24'hE0); ev(K_CLOSE, 0);
      bus.psram_ready = 1'b1;
      repeat (3) tick();
      req();
      repeat (4) tick();
      chk("bursts_page", {16'd0, bus.bursts_issued}, 32'd3);
      chk("enable_after_wrap", {31'd0, bus.psram_enable}, 32'd0);
      do_reset();
      // gap wait served at 5 cycles, closed at 9; then flush closes a contiguous burst
      push(24'h000500, 8'hD0);
      ev(K_SET, 24'h000500); ev(K_DATA, 24'hD0); ev(K_DATA, 24'hD1); ev(K_CLOSE, 0);
      ev(K_SET, 24'h000502); ev(K_DATA, 24'hD2); ev(K_CLOSE, 0);
      ev(K_SET, 24'h000503); ev(K_DATA, 24'hD3); ev(K_CLOSE, 0);
      bus.psram_ready = 1'b1;
      repeat (3) tick();
      req(); tick();
      req();
      repeat (4) tick();
      push(24'h000501, 8'hD1);
      repeat (3) tick();
      chk("gap_served_open", {31'd0, bus.psram_enable}, 32'd1);
      req();
      repeat (9) tick();
      chk("gap_timeout_closed", {31'd0, bus.psram_enable}, 32'd0);
      push(24'h000502, 8'hD2);
      repeat (4) tick();
      req();
      push(24'h000503, 8'hD3);
      pulse_flush();
      req();
      repeat (4) tick();
      req(); tick();
      req();
      repeat (12) tick();
      chk("bursts_gap", {16'd0, bus.bursts_issued}, 32'd3);
      do_reset();
      // full FIFO, overflow, then reset mid-burst
      for (int i = 0; i < 16; i++) push(24'h000600 + 24'(i), 8'h60 + 8'(i));
      chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("overflow_before", {31'd0, bus.overflow_flag}, 32'd0);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("overflow_set", {31'd0, bus.overflow_flag}, 32'd1);
      ev(K_SET, 24'h000600); ev(K_DATA, 24'h60); ev(K_DATA, 24'h61);
      bus.psram_ready = 1'b1;
      repeat (3) tick();
      req(); tick();
      req(); tick();
      chk("mid_burst_enable", {31'd0, bus.psram_enable}, 32'd1);
      reset = 1'b1;
      #1;
      chk("async_reset_enable", {31'd0, bus.psram_enable}, 32'd0);
      chk("async_reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("async_reset_overflow", {31'd0, bus.overflow_flag}, 32'd0);
      chk("async_reset_bursts", {16'd0, bus.bursts_issued}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("in_ready_after_midreset", {31'd0, bus.in_ready}, 32'd1);
      repeat (10) tick();
      chk("no_burst_after_reset", {16'd0, bus.bursts_issued}, 32'd0);
      ev(K_SET, 24'h000700); ev(K_DATA, 24'h77); ev(K_CLOSE, 0);
      push(24'h000700, 8'h77);
      repeat (3) tick();
      req(); tick();
      pulse_flush();
      req();
      repeat (4) tick();
      chk("bursts_final", {16'd0, bus.bursts_issued}, 32'd1);
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/psram_burst_writer.md
PSRAM_BURST_WRITER -- requirements
Module: psram_burst_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, number of buffered (address, byte) entries; power of two, >= 2.
REQ-002 Parameter MAX_BURST, default 32, maximum data bytes per PSRAM burst; 1..1024.
REQ-003 Parameter GAP_TIMEOUT, default 8, cycles a pending byte request waits on an empty FIFO before the burst closes.
REQ-004 sysclk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  upstream write request valid.
REQ-007 in_ready  out  1  FIFO can accept an entry this cycle.
REQ-008 in_address  in  24  PSRAM byte address of the write.
REQ-009 in_data  in  8  byte to write.
REQ-010 flush  in  1  single-cycle pulse; close the open burst at the next opportunity.
REQ-011 psram_ready  in  1  driver idle, able to start a burst.
REQ-012 psram_enable  out  1  burst active toward driver.
REQ-013 psram_rw  out  1  transfer direction; 1 = write, the only value driven.
REQ-014 psram_set_address  out  1  one-cycle pulse; psram_address valid.
REQ-015 psram_address  out  24  burst start address.
REQ-016 psram_next_byte_needed  in  1  one-cycle pulse; driver requests next data byte.
REQ-017 psram_write_data  out  1  one-cycle pulse; psram_data valid.
REQ-018 psram_data  out  8  data byte.
REQ-019 bursts_issued  out  16  count of bursts opened, wraps at 16'hFFFF -> 0.
REQ-020 overflow_flag  out  1  sticky; set if in_valid asserted while in_ready low.

Function
REQ-021 FIFO: push when in_valid && in_ready; in_ready = !full, registered from occupancy, no pass-through when full even with a same-cycle pop.
REQ-022 Simultaneous push and pop with FIFO neither full nor empty leaves occupancy unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-023 FSM states: IDLE, SET_ADDR, WAIT_REQ, WAIT_GAP, CLOSE.
REQ-024 IDLE: if FIFO non-empty && psram_ready, latch next_addr = head address, go SET_ADDR; else stay.
REQ-025 SET_ADDR: drive psram_enable=1, psram_rw=1, psram_set_address=1 for exactly one cycle with psram_address=next_addr; clear burst_count; increment bursts_issued; go WAIT_REQ.
REQ-026 psram_enable stays 1 from SET_ADDR through WAIT_REQ/WAIT_GAP, 0 in CLOSE and IDLE.
REQ-027 WAIT_REQ on psram_next_byte_needed: serve if FIFO non-empty && head address == next_addr && burst_count < MAX_BURST && no flush pending.
REQ-028 Serve: pop head, drive psram_data = head byte and pulse psram_write_data the next cycle (latency 1 from the request), next_addr += 1 (24-bit), burst_count += 1.
REQ-029 Request with FIFO empty and no other close condition: go WAIT_GAP, request held pending.
REQ-030 WAIT_GAP: serve per REQ-028 as soon as a contiguous head appears, return to WAIT_REQ; after GAP_TIMEOUT cycles with FIFO still empty go CLOSE.
REQ-031 Request with non-contiguous head, burst_count == MAX_BURST, or flush pending: go CLOSE, no data pulse.
REQ-032 Burst closes immediately after serving a byte whose incremented next_addr[9:0] == 0 (1 KiB page boundary), including 24'hFFFFFF -> 0.
REQ-033 flush latched in any state and cleared on entering CLOSE; flush in IDLE has no effect and is discarded.
REQ-034 CLOSE: one cycle with psram_enable=0, then IDLE; a new burst cannot start sooner than the cycle after CLOSE.
REQ-035 psram_next_byte_needed in IDLE, SET_ADDR or CLOSE is ignored.
REQ-036 psram_set_address and psram_write_data never asserted in the same cycle.

Reset
REQ-037 reset asserted: FSM -> IDLE, FIFO emptied, all outputs 0 (in_ready 0 during reset, 1 the first cycle after release), bursts_issued=0, overflow_flag=0, flush latch cleared, regardless of burst in progress.
REQ-038 Entries pending at reset are discarded; no pulse emitted after reset deassertion until a new push.

Verification
REQ-039 Push 4 bytes at 0x000100..0x000103, psram_ready=1, 4 request pulses -> one set_address at 0x000100, data pulses in order, then CLOSE, bursts_issued=1.
REQ-040 Push 0x000010, 0x000020 -> second request closes burst; new burst at 0x000020, bursts_issued=2.
REQ-041 Push 40 contiguous bytes from 0x0, MAX_BURST=32 -> bursts of 32 and 8, second at 0x000020.
REQ-042 Push 0x0003FE, 0x0003FF, 0x000400 -> burst closes after 0x0003FF; next burst starts at 0x000400.
REQ-043 Request on empty FIFO, push contiguous byte after 5 cycles -> served, no close; repeat waiting 9 cycles -> CLOSE.
REQ-044 Fill FIFO to 16, assert in_valid -> in_ready=0, overflow_flag=1; reset mid-burst -> psram_enable=0 asynchronously, FIFO empty.
